// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data has priority, but a streak counter bounds how long fetch can be starved.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_DSTREAK = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              busy
);

    localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

    typedef enum logic [1:0] {StIdle, StDServ, StIServ, StDone} state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   store_q, store_d;
    logic                wr_q, wr_d;
    // Remembers which requester owns the access so DONE pulses the right hit.
    logic                dsel_q, dsel_d;
    logic [DATA_W-1:0]   iload_q, iload_d;
    logic [DATA_W-1:0]   dload_q, dload_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            streak_q <= '0;
            addr_q   <= '0;
            store_q  <= '0;
            wr_q     <= 1'b0;
            dsel_q   <= 1'b0;
            iload_q  <= '0;
            dload_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wr_q     <= wr_d;
            dsel_q   <= dsel_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        dsel_d   = dsel_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        unique case (state_q)
            StIdle: begin
                if ((dREN || dWEN) && ((streak_q < STREAK_MAX) || !iREN)) begin
                    state_d = StDServ;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                    dsel_d  = 1'b1;
                end else if (iREN) begin
                    state_d = StIServ;
                    addr_d  = iaddr;
                    wr_d    = 1'b0;
                    dsel_d  = 1'b0;
                end
            end
            StDServ: begin
                if (ram_ready) begin
                    state_d = StDone;
                    if (!wr_q) begin
                        dload_d = ramload;
                    end
                    if (!iREN) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            StIServ: begin
                if (ram_ready) begin
                    state_d  = StDone;
                    iload_d  = ramload;
                    streak_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ramREN   = ((state_q == StDServ) && !wr_q) || (state_q == StIServ);
        ramWEN   = (state_q == StDServ) && wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        busy     = (state_q == StDServ) || (state_q == StIServ);
        ihit     = (state_q == StDone) && !dsel_q;
        dhit     = (state_q == StDone) && dsel_q;
        iload    = iload_q;
        dload    = dload_q;
    end

endmodule
